// File: rtl/pc_pkg.sv
// Shared state type, default vectors and helpers for the pc_gen program-counter block.
// PC_ALIGN_CHECK_EN (optional) turns misaligned redirects into exceptions.
package pc_pkg;

  localparam int          PC_WIDTH     = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
  localparam int          PC_INC       = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } pc_state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority mux choosing the next PC, EPC and state of pc_gen.
// With PC_ALIGN_CHECK_EN a misaligned accepted redirect becomes an exception (RUN) or a double fault (HANDLER).
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH   = PC_WIDTH,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(PC_EXC_VEC),
  parameter int               INC     = PC_INC
) (
  input  pc_state_t          state,
  input  logic [WIDTH-1:0]   pc,
  input  logic [WIDTH-1:0]   epc,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  input  logic               exc_req,
  input  logic [WIDTH-1:0]   exc_pc,
  input  logic               exc_bd,
  input  logic               irq_active,
  input  logic               eret,
  output logic [WIDTH-1:0]   next_pc,
  output logic [WIDTH-1:0]   next_epc,
  output pc_state_t          next_state,
  output logic               enter,
  output logic               take_irq,
`ifdef PC_ALIGN_CHECK_EN
  output logic               bad_redirect,
`endif
  output logic               fault
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INC);

  logic redirect_bad;

`ifdef PC_ALIGN_CHECK_EN
  assign redirect_bad = redirect_valid && is_misaligned(redirect_pc[1:0]);
`else
  assign redirect_bad = 1'b0;
`endif

  // A faulting request inside the handler only flags the double fault; the PC holds.
  always_comb begin
    next_pc    = pc;
    next_epc   = epc;
    next_state = state;
    enter      = 1'b0;
    take_irq   = 1'b0;
    fault      = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    bad_redirect = 1'b0;
`endif
    if (state == RUN) begin
      if (exc_req) begin
        next_pc    = EXC_VEC;
        next_epc   = exc_bd ? exc_pc - STEP : exc_pc;
        next_state = HANDLER;
        enter      = 1'b1;
      end else if (irq_active) begin
        next_pc    = EXC_VEC;
        next_epc   = pc;
        next_state = HANDLER;
        enter      = 1'b1;
        take_irq   = 1'b1;
      end else if (stall) begin
        next_pc = pc;
      end else if (redirect_bad) begin
        next_pc    = EXC_VEC;
        next_epc   = redirect_pc;
        next_state = HANDLER;
        enter      = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        bad_redirect = 1'b1;
`endif
      end else if (redirect_valid) begin
        next_pc = redirect_pc;
      end else begin
        next_pc = pc + STEP;
      end
    end else begin
      if (exc_req) begin
        fault = 1'b1;
      end else if (eret && !stall) begin
        next_pc    = epc;
        next_state = RUN;
      end else if (stall) begin
        next_pc = pc;
      end else if (redirect_bad) begin
        fault = 1'b1;
      end else if (redirect_valid) begin
        next_pc = redirect_pc;
      end else begin
        next_pc = pc + STEP;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with exception/interrupt entry, eret and exception counting.
// Define PC_ALIGN_CHECK_EN to add the misaligned-redirect trap and the pc_misaligned output.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int               INC       = PC_INC,
  parameter int               CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  input  logic               exc_req,
  input  logic [WIDTH-1:0]   exc_pc,
  input  logic               exc_bd,
  input  logic               irq,
  input  logic               eret,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   epc,
  output logic               in_handler,
  output logic               exc_taken,
`ifdef PC_ALIGN_CHECK_EN
  output logic               pc_misaligned,
`endif
  output logic               double_fault,
  output logic [CNT_W-1:0]   exc_count
);

  pc_state_t        state;
  pc_state_t        next_state;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] next_epc;
  logic             irq_pend;
  logic             enter;
  logic             take_irq;
  logic             fault;
`ifdef PC_ALIGN_CHECK_EN
  logic             bad_redirect;
`endif

  pc_next_sel #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC),
    .INC     (INC)
  ) u_next_sel (
    .state          (state),
    .pc             (pc),
    .epc            (epc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .exc_pc         (exc_pc),
    .exc_bd         (exc_bd),
    .irq_active     (irq | irq_pend),
    .eret           (eret),
    .next_pc        (next_pc),
    .next_epc       (next_epc),
    .next_state     (next_state),
    .enter          (enter),
    .take_irq       (take_irq),
`ifdef PC_ALIGN_CHECK_EN
    .bad_redirect   (bad_redirect),
`endif
    .fault          (fault)
  );

  // An interrupt taken on the same edge it arrives clears the pending latch rather than setting it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_VEC;
      epc          <= '0;
      state        <= RUN;
      irq_pend     <= 1'b0;
      exc_taken    <= 1'b0;
      double_fault <= 1'b0;
      exc_count    <= '0;
`ifdef PC_ALIGN_CHECK_EN
      pc_misaligned <= 1'b0;
`endif
    end else begin
      pc        <= next_pc;
      epc       <= next_epc;
      state     <= next_state;
      irq_pend  <= take_irq ? 1'b0 : (irq_pend | irq);
      exc_taken <= enter;
`ifdef PC_ALIGN_CHECK_EN
      pc_misaligned <= bad_redirect;
`endif
      if (fault) begin
        double_fault <= 1'b1;
      end
      if (enter && (exc_count != {CNT_W{1'b1}})) begin
        exc_count <= exc_count + 1'b1;
      end
    end
  end

  assign in_handler = (state == HANDLER);

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator. Successor to the single-register PC with reset, interrupt vector and write enable.
- Adds sequential increment, branch/jump redirect, exception-PC (EPC) capture with branch-delay correction, and an in-handler state with interrupt masking.
- Adds a pending-interrupt latch, exception return (eret) and a saturating exception counter.
- Sits at the fetch stage; drives the instruction-memory address; receives redirects and exception requests from later pipeline stages.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_VEC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry PC.
- INC, 4, sequential PC increment in bytes.
- CNT_W, 8, exception-counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; active-high.
- redirect_valid  in  1  take redirect_pc next cycle.
- redirect_pc  in  WIDTH  branch/jump target.
- exc_req  in  1  synchronous exception from pipeline.
- exc_pc  in  WIDTH  PC of faulting instruction.
- exc_bd  in  1  faulting instruction sits in a delay slot.
- irq  in  1  external interrupt pulse.
- eret  in  1  return from handler.
- pc  out  WIDTH  current fetch PC.
- epc  out  WIDTH  saved return PC.
- in_handler  out  1  state == HANDLER.
- exc_taken  out  1  one-cycle pulse on the cycle after handler entry.
- double_fault  out  1  sticky; exc_req seen while in HANDLER.
- exc_count  out  CNT_W  saturating count of handler entries.

Behaviour:
- Reset (async, any time, including mid-handler):
  - pc = RESET_VEC, epc = 0, state = RUN.
  - irq_pend = 0, exc_taken = 0, double_fault = 0, exc_count = 0.
- States: RUN, HANDLER.
- irq_pend:
  - Set on any cycle irq = 1.
  - Cleared on the edge where an interrupt is taken.
  - Set and clear in the same cycle resolves as clear.
- RUN, per clock edge, first match wins:
  1. exc_req: pc = EXC_VEC; epc = exc_bd ? exc_pc - INC : exc_pc; state = HANDLER.
  2. irq or irq_pend: pc = EXC_VEC; epc = pc, i.e. the not-yet-executed instruction; state = HANDLER; irq_pend cleared.
  3. stall: hold pc.
  4. redirect_valid: pc = redirect_pc.
  5. else: pc = pc + INC.
- Exception and interrupt entry ignore stall.
- eret in RUN is ignored; pc advances per rules 3-5.
- HANDLER, per clock edge, first match wins:
  1. exc_req: set double_fault; otherwise ignored (no epc change).
  2. eret and not stall: pc = epc; state = RUN.
  3. stall: hold.
  4. redirect_valid: pc = redirect_pc.
  5. else: pc + INC.
- Interrupts arriving in HANDLER only set irq_pend.
- A pending interrupt is taken on the first edge after eret returns to RUN. epc then equals the return PC, so the net effect is re-entry with an unchanged epc.
- On each handler entry:
  - exc_taken = 1 for exactly one cycle, then 0.
  - exc_count increments, saturating at 2^CNT_W - 1.
- Arithmetic is modulo 2^WIDTH; pc + INC wraps silently; exc_pc - INC wraps at 0.
- All outputs are registered; latency from any input to pc is one edge.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect_pc with redirect_pc[1:0] != 0, accepted in RUN, is treated as an exception instead of the redirect.
  - pc = EXC_VEC, epc = redirect_pc, state = HANDLER.
  - New output pc_misaligned (1 bit) pulses high for one cycle together with exc_taken.
  - In HANDLER, a misaligned redirect sets double_fault and holds pc.
- Undefined: no check; redirect_pc is loaded verbatim; no pc_misaligned port.

Decomposition:
- Package pc_pkg holds:
  - State enum pc_state_t {RUN, HANDLER}.
  - Default constants PC_RESET_VEC, PC_EXC_VEC, PC_INC.
  - Typedef pc_t as a WIDTH-bit vector.
- One natural sub-module, pc_next_sel: purely combinational priority mux producing next_pc, next_state and entry flags.
- Registers, irq_pend, counter and state live in pc_gen.

Test Plan:
- Reset/sequence: assert reset mid-cycle, release; 3 idle edges -> pc 0x3000, 0x3004, 0x3008, 0x300C; epc = 0, exc_count = 0.
- Redirect vs stall: redirect_valid with redirect_pc = 0x3100 while stall = 1 -> pc held; drop stall -> pc = 0x3100 next edge.
- Delay-slot exception: exc_req, exc_bd = 1, exc_pc = 0x3010, stall = 1 -> pc = 0x4180, epc = 0x300C, in_handler = 1, exc_taken one cycle, exc_count = 1.
- Masked interrupt: in HANDLER pulse irq -> no pc change. Then eret with epc = 0x3020 -> pc = 0x3020; next edge pc = 0x4180, epc = 0x3020, exc_count = 2.
- Double fault / async reset: exc_req in HANDLER -> double_fault = 1, epc unchanged. Assert reset between edges -> pc = 0x3000, double_fault = 0, in_handler = 0 immediately.
- Wrap and saturation: force pc = 0xFFFF_FFFC with WIDTH = 32 -> next pc = 0x0000_0000. With CNT_W = 2, 5 handler entries -> exc_count = 3.
